// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: block sequencer for the SHA-256 compression round datapath.
// Each accepted start runs LOAD, ROUNDS round cycles, UPDATE, then DONE.
// Optional feature macro: SHA256_CTRL_STALL_EN adds stall_i, which freezes ROUND.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start_i           block request, sampled only when idle
//   init_i, last_i    first/final block flags, captured with an accepted start
//   stall_i           (SHA256_CTRL_STALL_EN only) hold the round counter in ROUND
//   busy_o, done_o    sequencer active / one-cycle completion pulse
//   digest_valid_o    hash register holds the final message digest
//   sel_o, sel_a_o    working-variable mux selects (1 = hash/IV side)
//   iv_sel_o          hash-side source select (1 = IV constants)
//   hash_iv_load_o    load IV into the hash register
//   wreg_en_o         working registers a..h capture enable
//   round_idx_o       round number for K ROM and message schedule
//   w_msg_sel_o       W source (1 = message word, rounds 0..15)
//   hash_upd_o        hash register accumulate enable
module sha256_round_ctrl #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             init_i,
    input  logic             last_i,
`ifdef SHA256_CTRL_STALL_EN
    input  logic             stall_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             digest_valid_o,
    output logic             sel_o,
    output logic             sel_a_o,
    output logic             iv_sel_o,
    output logic             hash_iv_load_o,
    output logic             wreg_en_o,
    output logic [CNT_W-1:0] round_idx_o,
    output logic             w_msg_sel_o,
    output logic             hash_upd_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_q, init_d;
    logic             last_q, last_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dv_q, dv_d;
    logic             sel_q, sel_d;
    logic             sel_a_q, sel_a_d;
    logic             iv_sel_q, iv_sel_d;
    logic             hiv_q, hiv_d;
    logic             wreg_en_q, wreg_en_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             wmsg_q, wmsg_d;
    logic             hupd_q, hupd_d;

    logic             hold_c;
    logic             stalled_c;

`ifdef SHA256_CTRL_STALL_EN
    assign hold_c = stall_i;
`else
    assign hold_c = 1'b0;
`endif

    // Stall only has effect while rounds are running.
    assign stalled_c = (state_q == S_ROUND) && hold_c;

    // Next state, counter, and output decode from the upcoming state so outputs line up with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    init_d  = init_i;
                    last_d  = last_i;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (!hold_c) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_UPDATE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_UPDATE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        sel_d     = (state_d == S_LOAD);
        sel_a_d   = (state_d == S_LOAD);
        iv_sel_d  = (state_d == S_LOAD) && init_d;
        hiv_d     = (state_d == S_LOAD) && init_d;
        wreg_en_d = (state_d == S_LOAD) || ((state_d == S_ROUND) && !stalled_c);
        idx_d     = (state_d == S_ROUND) ? cnt_d : '0;
        wmsg_d    = (state_d == S_ROUND) && (32'(cnt_d) < 32'd16);
        hupd_d    = (state_d == S_UPDATE);

        // Digest flag: cleared by a new block, set when a final block completes.
        dv_d = dv_q;
        if (state_d == S_LOAD) begin
            dv_d = 1'b0;
        end else if ((state_d == S_DONE) && last_d) begin
            dv_d = 1'b1;
        end
    end

    // State, counter, latched flags and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            init_q    <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dv_q      <= 1'b0;
            sel_q     <= 1'b0;
            sel_a_q   <= 1'b0;
            iv_sel_q  <= 1'b0;
            hiv_q     <= 1'b0;
            wreg_en_q <= 1'b0;
            idx_q     <= '0;
            wmsg_q    <= 1'b0;
            hupd_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_q    <= init_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dv_q      <= dv_d;
            sel_q     <= sel_d;
            sel_a_q   <= sel_a_d;
            iv_sel_q  <= iv_sel_d;
            hiv_q     <= hiv_d;
            wreg_en_q <= wreg_en_d;
            idx_q     <= idx_d;
            wmsg_q    <= wmsg_d;
            hupd_q    <= hupd_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign digest_valid_o = dv_q;
    assign sel_o          = sel_q;
    assign sel_a_o        = sel_a_q;
    assign iv_sel_o       = iv_sel_q;
    assign hash_iv_load_o = hiv_q;
    assign wreg_en_o      = wreg_en_q;
    assign round_idx_o    = idx_q;
    assign w_msg_sel_o    = wmsg_q;
    assign hash_upd_o     = hupd_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a 64-round and a 4-round instance share stimulus;
// a block-phase model predicts every output each cycle, plus literal spot checks.
module tb_sha256_round_ctrl;

    logic clk = 1'b0;
    logic rst, start, init, last, stall;

    always #5 clk = ~clk;

    logic       busy0, done0, dv0, sel0, sela0, ivs0, hiv0, wen0, wms0, hup0;
    logic [5:0] idx0;
    logic       busy1, done1, dv1, sel1, sela1, ivs1, hiv1, wen1, wms1, hup1;
    logic [1:0] idx1;

    sha256_round_ctrl #(.ROUNDS(64), .CNT_W(6)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .init_i(init), .last_i(last),
`ifdef SHA256_CTRL_STALL_EN
        .stall_i(stall),
`endif
        .busy_o(busy0), .done_o(done0), .digest_valid_o(dv0), .sel_o(sel0),
        .sel_a_o(sela0), .iv_sel_o(ivs0), .hash_iv_load_o(hiv0), .wreg_en_o(wen0),
        .round_idx_o(idx0), .w_msg_sel_o(wms0), .hash_upd_o(hup0)
    );

    sha256_round_ctrl #(.ROUNDS(4), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .init_i(init), .last_i(last),
`ifdef SHA256_CTRL_STALL_EN
        .stall_i(stall),
`endif
        .busy_o(busy1), .done_o(done1), .digest_valid_o(dv1), .sel_o(sel1),
        .sel_a_o(sela1), .iv_sel_o(ivs1), .hash_iv_load_o(hiv1), .wreg_en_o(wen1),
        .round_idx_o(idx1), .w_msg_sel_o(wms1), .hash_upd_o(hup1)
    );

    int total = 0;
    int bad   = 0;
    int rel   = 0;
    bit chk_en = 1'b0;

    // Model: p = cycles since the accepting cycle (1 = LOAD, 2..R+1 rounds, R+2 update, R+3 done).
    bit act [2];
    int p   [2];
    bit held[2];
    bit il  [2];
    bit ll  [2];
    bit dv  [2];

    function automatic int rounds_of(int d);
        return (d == 0) ? 64 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h rel=%0d t=%0t", name, a, e, rel, $time);
        end
    endtask

    task automatic model_step(input int d);
        int  r;
        bit  st;
        r  = rounds_of(d);
`ifdef SHA256_CTRL_STALL_EN
        st = stall;
`else
        st = 1'b0;
`endif
        if (rst) begin
            act[d] = 0; p[d] = 0; held[d] = 0; dv[d] = 0;
        end else if (!act[d]) begin
            held[d] = 0;
            if (start) begin
                act[d] = 1; p[d] = 1; il[d] = init; ll[d] = last; dv[d] = 0;
            end
        end else if (p[d] >= 2 && p[d] <= r + 1 && st) begin
            held[d] = 1;
        end else begin
            held[d] = 0;
            p[d]++;
            if (p[d] == r + 3 && ll[d]) dv[d] = 1;
            if (p[d] > r + 3) begin
                act[d] = 0; p[d] = 0;
            end
        end
    endtask

    function automatic logic [15:0] exp_vec(input int d);
        int r;
        bit rnd;
        int ix;
        r   = rounds_of(d);
        rnd = act[d] && p[d] >= 2 && p[d] <= r + 1;
        ix  = rnd ? p[d] - 2 : 0;
        return {act[d], act[d] && p[d] == r + 3, dv[d], p[d] == 1, p[d] == 1,
                p[d] == 1 && il[d], p[d] == 1 && il[d],
                p[d] == 1 || (rnd && !held[d]), rnd && ix < 16,
                act[d] && p[d] == r + 2, 6'(ix)};
    endfunction

    function automatic logic [15:0] dut_vec(input int d);
        if (d == 0)
            return {busy0, done0, dv0, sel0, sela0, ivs0, hiv0, wen0, wms0, hup0, idx0};
        return {busy1, done1, dv1, sel1, sela1, ivs1, hiv1, wen1, wms1, hup1, 4'b0, idx1};
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            act[d] = 0; p[d] = 0; held[d] = 0; il[d] = 0; ll[d] = 0; dv[d] = 0;
        end
    end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("r64_outputs", 32'(dut_vec(0)), 32'(exp_vec(0)));
            check("r4_outputs",  32'(dut_vec(1)), 32'(exp_vec(1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic goto(input int k);
        while (rel < k) tick();
    endtask

    // Present a one-cycle start; returns at cycle 1 (LOAD).
    task automatic go(input bit i, input bit l);
        start = 1; init = i; last = l; rel = 0;
        tick();
        start = 0; init = 0; last = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog rel=%0d", rel);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; start = 0; init = 0; last = 0; stall = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 0;
        check("reset_state", 32'(dut_vec(0)), 32'h0);

        // Single block, first and last.
        go(1, 1);
        check("t1_load", 32'({sel0, sela0, ivs0, hiv0, wen0}), 32'h1f);
        check("t1_r4_load_sel", 32'(sel1), 32'h1);
        goto(2);  check("t1_idx0", 32'(idx0), 32'd0);
        goto(5);  check("t1_r4_idx3", 32'(idx1), 32'd3);
        goto(6);  check("t1_r4_upd", 32'(hup1), 32'h1);
        goto(7);  check("t1_r4_done", 32'(done1), 32'h1);
        goto(17); check("t1_msg15", 32'({wms0, idx0}), 32'h4f);
        goto(18); check("t1_sched16", 32'({wms0, idx0}), 32'h10);
        goto(65); check("t1_idx63", 32'(idx0), 32'd63);
        goto(66); check("t1_upd", 32'({hup0, wen0}), 32'h2);
        goto(67); check("t1_done", 32'({done0, dv0, busy0}), 32'h7);
        goto(70); check("t1_dv_hold", 32'({done0, dv0, busy0}), 32'h2);

        // Two-block message.
        go(1, 0);
        check("t2_load1_dvclr", 32'({ivs0, dv0}), 32'h2);
        goto(67); check("t2_done1", 32'({done0, dv0}), 32'h2);
        goto(69);
        go(0, 1);
        check("t2_load2", 32'({sel0, sela0, ivs0, hiv0}), 32'h c);
        goto(67); check("t2_done2", 32'({done0, dv0}), 32'h3);
        goto(69);

        // start held high for 80 cycles.
        start = 1; init = 1; last = 1; rel = 0;
        goto(67); check("t3_done", 32'(done0), 32'h1);
        goto(68); check("t3_idle", 32'({busy0, sel0}), 32'h0);
        goto(69); check("t3_reload", 32'({busy0, sel0}), 32'h3);
        goto(80); start = 0; init = 0; last = 0;
        goto(135); check("t3_done2", 32'(done0), 32'h1);
        goto(137);

        // Reset mid-round.
        go(1, 1);
        goto(32); check("t4_idx30", 32'(idx0), 32'd30);
        rst = 1;
        tick();
        rst = 0;
        check("t4_abort", 32'(dut_vec(0)), 32'h0);
        goto(35);
        go(1, 1);
        goto(65); check("t4_idx63", 32'(idx0), 32'd63);
        goto(66); check("t4_upd", 32'(hup0), 32'h1);
        goto(67); check("t4_done", 32'({done0, dv0}), 32'h3);
        goto(69);

`ifdef SHA256_CTRL_STALL_EN
        // Stall three cycles at round 10.
        go(1, 1);
        goto(12); check("t5_idx10", 32'(idx0), 32'd10);
        stall = 1;
        goto(13); check("t5_hold13", 32'({wen0, idx0}), 32'd10);
        goto(15); check("t5_hold15", 32'({wen0, idx0}), 32'd10);
        stall = 0;
        goto(16); check("t5_resume", 32'({wen0, idx0}), 32'h4b);
        goto(70); check("t5_done", 32'(done0), 32'h1);
        goto(72);
`endif

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencer for the SHA-256 compression core. It drives the working-variable pairwise multiplexer selects (sel, sel_a), the round index for the K ROM and the message schedule, and the working-register and hash-register enables. Each accepted start runs one 512-bit block: load, 64 rounds, hash update, done. It sits between the message/padding front end and the round datapath.

Parameters:
ROUNDS, 64, number of compression rounds per block. Non-64 values are for simulation shortening only; legal range is 2..64.
CNT_W, 6, width of round_idx; must satisfy 2^CNT_W >= ROUNDS.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  block request; sampled only in IDLE
init  in  1  first block of a message; sampled with accepted start
last  in  1  final block of a message; sampled with accepted start
busy  out  1  high in LOAD, ROUND, UPDATE and DONE
done  out  1  one-cycle pulse in DONE
digest_valid  out  1  hash register holds the final digest
sel  out  1  mux select for b..h: 1 = hash/IV source, 0 = round feedback
sel_a  out  1  mux select for a, same encoding
iv_sel  out  1  hash-side mux source: 1 = IV constants, 0 = hash register
hash_iv_load  out  1  hash register <= IV
wreg_en  out  1  working registers a..h capture mux output
round_idx  out  CNT_W  current round number
w_msg_sel  out  1  W source: 1 = message word (rounds 0..15), 0 = schedule recurrence
hash_upd  out  1  hash register <= hash + working variables
stall  in  1  present only with SHA256_CTRL_STALL_EN; see Optional Feature

Behaviour:
- All outputs are registered and decoded from state and counter. Reset value of every output is 0. State resets to IDLE and the counter resets to 0.
- IDLE: busy=0. If start=1, latch init and last, then go to LOAD. If start=0, stay in IDLE.
- LOAD (1 cycle): sel=1, sel_a=1, wreg_en=1, round_idx=0.
  - iv_sel equals latched init.
  - hash_iv_load equals latched init.
  - digest_valid cleared.
  - Next state: ROUND.
- ROUND (ROUNDS cycles): sel=0, sel_a=0, wreg_en=1.
  - round_idx equals the counter and increments each cycle.
  - w_msg_sel=1 while round_idx<16.
  - When round_idx=ROUNDS-1, go to UPDATE and reset the counter to 0.
- UPDATE (1 cycle): hash_upd=1, wreg_en=0, sel=0. Next state: DONE.
- DONE (1 cycle): done=1. If latched last=1, set digest_valid. Next state: IDLE.
- digest_valid stays high until the next LOAD or until rst.
- Latency: with start accepted in cycle 0, LOAD is cycle 1, rounds run in cycles 2..ROUNDS+1, UPDATE is ROUNDS+2, DONE is ROUNDS+3 (67 at the default).
- start while busy=1, including the DONE cycle, is ignored and never queued.
- init and last are ignored outside an accepted start.
- sel_a equals sel in every state. It is a separate flop so the a-path select can be placed independently.
- rst in any state takes priority over every transition. The next cycle is IDLE with all outputs 0 and no partial hash_upd.

Optional Feature:
SHA256_CTRL_STALL_EN:
- Defined: the stall port exists. In ROUND, stall=1 freezes the counter and round_idx and forces wreg_en=0. w_msg_sel keeps its value. The state does not advance.
- stall is ignored in all other states.
- Not defined: no stall port, and ROUND always advances.

Test Plan:
1. rst, then start=1, init=1, last=1 in cycle 0 -> cycle 1: sel=sel_a=iv_sel=hash_iv_load=1; cycles 2..65: round_idx 0..63, w_msg_sel=1 in cycles 2..17; cycle 66: hash_upd=1; cycle 67: done=1 and digest_valid=1, held until the next start.
2. Two blocks: first block init=1, last=0; second block init=0, last=1 -> after block 1, done=1 with digest_valid=0; block 2 LOAD has iv_sel=0 and hash_iv_load=0; digest_valid=1 after block 2 DONE.
3. start held high for 80 cycles -> blocks accepted at cycles 0 and 68 only; no start accepted in the DONE cycle 67.
4. rst in cycle 32 (round_idx=30) -> cycle 33: all outputs 0, IDLE; a new start runs the full 64 rounds and hash_upd is never seen for the aborted block.
5. With SHA256_CTRL_STALL_EN: stall=1 for 3 cycles while round_idx=10 -> round_idx holds at 10, wreg_en=0 for those 3 cycles, done in cycle 70.
6. ROUNDS=4 -> round_idx 0..3 in cycles 2..5, hash_upd in cycle 6, done in cycle 7.
